hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and stall controller for the 16-bit five-stage core. Consumes the decode-stage source register indices and the ID/EX control outputs. Returns the enable, bubble and flush controls that drive the PC, IF/ID and ID/EX registers. It also sequences data-cache waits, branch flushes and halt drain, and keeps a saturating stall counter.

## Interface
- `RW`, default 3: register index width.
- `CNT_W`, default 16: stall counter width.
- `DRAIN`, default 2: cycles from `halt_ID_EX` to retirement (MEM, WB).

Ports (name, direction, width, meaning):
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: **reset is asynchronous and active-low.** Asserted at 0, independent of `clk`.
- `read_reg1`, in, RW: rs index of the instruction in ID.
- `read_reg2`, in, RW: rt index of the instruction in ID.
- `rd1_used`, in, 1: ID instruction actually reads `read_reg1`.
- `rd2_used`, in, 1: ID instruction actually reads `read_reg2`.
- `w1_reg_ID_EX`, in, RW: destination register of the instruction in EX.
- `reg_en_ID_EX`, in, 1: EX instruction writes the register file.
- `mem_en_ID_EX`, in, 1: EX instruction accesses memory.
- `mem_wr_ID_EX`, in, 1: EX instruction is a store.
- `halt_ID_EX`, in, 1: EX instruction is HALT.
- `branch_taken`, in, 1: EX resolved a taken branch or jump this cycle.
- `mem_req`, in, 1: MEM stage issues a cache access this cycle.
- `mem_done`, in, 1: cache completes the outstanding access (one-cycle pulse).
- `pc_en`, out, 1: PC register write enable.
- `if_id_en`, out, 1: IF/ID register write enable.
- `if_id_flush`, out, 1: load a NOP into IF/ID on the next edge.
- `id_ex_bubble`, out, 1: zero the control fields of ID/EX on the next edge.
- `pipe_freeze`, out, 1: hold ID/EX, EX/MEM and MEM/WB.
- `halted`, out, 1: core has retired HALT; sticky until reset.
- `stall_cnt`, out, CNT_W: count of cycles with `pc_en`=0, saturating.

## Operation
- **Load-use hazard (combinational, RUN only):** `lu = mem_en_ID_EX & ~mem_wr_ID_EX & reg_en_ID_EX & ((rd1_used & read_reg1==w1_reg_ID_EX) | (rd2_used & read_reg2==w1_reg_ID_EX))`.
- **States:** RUN, MEM_WAIT, HALT_DRAIN, HALTED. Encoded as 2 bits.
- **RUN:**
  - Outputs: `pc_en`=`if_id_en`=~lu, `id_ex_bubble`=lu|branch_taken, `if_id_flush`=branch_taken.
  - `mem_req` & ~`mem_done` → MEM_WAIT.
  - `halt_ID_EX` & ~`branch_taken` → HALT_DRAIN; load drain counter with DRAIN.
- **MEM_WAIT:**
  - `pipe_freeze`=1, `pc_en`=`if_id_en`=0, bubble=0.
  - A `branch_taken` seen on the entry cycle sets `flush_pend`.
  - On `mem_done` → RUN. If `flush_pend` is set, assert `if_id_flush` and `id_ex_bubble` in that exit cycle, then clear `flush_pend`.
- **HALT_DRAIN:**
  - `pc_en`=`if_id_en`=0, `id_ex_bubble`=1.
  - Counter decrements each cycle; `mem_req` waits behave as in MEM_WAIT, and the counter holds while waiting.
  - Counter reaches 0 → HALTED.
- **HALTED:** `halted`=1; all enables 0. Leave only by reset.
- **Priority:** reset > MEM_WAIT > branch flush > load-use > normal. Branch plus load-use in the same cycle: flush wins, and `pc_en`=1 so the branch target is fetched.
- **stall_cnt:** increments on every cycle with `pc_en`=0 outside HALTED. Holds at all-ones.

## Timing
- **Reset values:** state=RUN, `flush_pend`=0, `stall_cnt`=0, `halted`=0. Outputs while `rst`=0: `pc_en`=`if_id_en`=1, and `if_id_flush`, `id_ex_bubble`, `pipe_freeze` all 0.
- **Load-use:** costs exactly 1 bubble cycle. `lu` clears once the load moves to MEM.
- **Branch:** flush is asserted in the same cycle as `branch_taken`. Two younger instructions are killed.
- **`mem_done` in the same cycle as `mem_req`:** zero-wait access, no state change.
- **`mem_done` while in RUN:** ignored.
- **Reset mid-wait or mid-drain:** returns to RUN immediately (asynchronous); `flush_pend` is lost.

## Structure
- Shared core package holds the state enum (RUN=0, MEM_WAIT=1, HALT_DRAIN=2, HALTED=3) and RW.
- Single module, no sub-modules. The saturating counter is inline.

## Test plan
- **Load-use:** load r3 in EX, `read_reg1`=3, `rd1_used`=1 → one cycle with `pc_en`=0 and `id_ex_bubble`=1; `stall_cnt`=1.
- **Store, no hazard:** store with the same index (`mem_wr_ID_EX`=1) → no stall.
- **Unused source:** `rd2_used`=0 with matching `read_reg2` → no stall.
- **Branch flush:** `branch_taken`=1 with `lu`=1 → `if_id_flush`=1, `id_ex_bubble`=1, `pc_en`=1.
- **Cache miss:** `mem_req`=1, `mem_done` 4 cycles later → `pipe_freeze`=1 for 4 cycles, `stall_cnt`=4. Same run with `branch_taken` on the entry cycle → flush asserted on the exit cycle.
- **Halt:** `halt_ID_EX`=1 → `halted`=1 after 2 cycles. A 3-cycle miss during the drain delays `halted` to cycle 5.
- **Reset:** `rst` low mid-MEM_WAIT → asynchronous return to RUN, `stall_cnt`=0. Counter saturation: 2^16+5 forced stalls → `stall_cnt`=16'hFFFF.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared core definitions for the hazard/stall controller: default register
// index width and the controller state encoding.
package hazard_ctrl_pkg;

  localparam int unsigned RW_DEFAULT = 3;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_MEM_WAIT   = 2'd1,
    ST_HALT_DRAIN = 2'd2,
    ST_HALTED     = 2'd3
  } hz_state_e;

endpackage

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall controller: load-use bubbles, branch flushes,
// data-cache wait freezes, HALT drain and a saturating stall counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned RW    = RW_DEFAULT,
  parameter int unsigned CNT_W = 16,
  parameter int unsigned DRAIN = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RW-1:0]    read_reg1,
  input  logic [RW-1:0]    read_reg2,
  input  logic             rd1_used,
  input  logic             rd2_used,
  input  logic [RW-1:0]    w1_reg_ID_EX,
  input  logic             reg_en_ID_EX,
  input  logic             mem_en_ID_EX,
  input  logic             mem_wr_ID_EX,
  input  logic             halt_ID_EX,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_done,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             pipe_freeze,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned DW = (DRAIN < 1) ? 1 : $clog2(DRAIN + 1);

  hz_state_e        state_q, state_d;
  logic             flush_pend_q, flush_pend_d;
  logic             wait_q, wait_d;
  logic [DW-1:0]    drain_q, drain_d, drain_dec;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic hit1, hit2, lu, miss;
  logic pc_en_c, if_id_en_c, if_id_flush_c, id_ex_bubble_c, pipe_freeze_c;

  assign hit1      = rd1_used && (read_reg1 == w1_reg_ID_EX);
  assign hit2      = rd2_used && (read_reg2 == w1_reg_ID_EX);
  assign lu        = mem_en_ID_EX & ~mem_wr_ID_EX & reg_en_ID_EX & (hit1 | hit2);
  assign miss      = mem_req & ~mem_done;
  assign drain_dec = (drain_q == '0) ? '0 : drain_q - 1'b1;

  always_comb begin
    state_d        = state_q;
    flush_pend_d   = flush_pend_q;
    wait_d         = wait_q;
    drain_d        = drain_q;
    pc_en_c        = 1'b1;
    if_id_en_c     = 1'b1;
    if_id_flush_c  = 1'b0;
    id_ex_bubble_c = 1'b0;
    pipe_freeze_c  = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (miss) begin
          // Wait outranks the flush: a branch on the entry cycle is deferred to the exit cycle.
          state_d        = ST_MEM_WAIT;
          flush_pend_d   = branch_taken;
          pc_en_c        = ~lu;
          if_id_en_c     = ~lu;
          id_ex_bubble_c = lu;
        end else begin
          pc_en_c        = ~lu | branch_taken;
          if_id_en_c     = ~lu | branch_taken;
          if_id_flush_c  = branch_taken;
          id_ex_bubble_c = lu | branch_taken;
          if (halt_ID_EX && !branch_taken) begin
            state_d = ST_HALT_DRAIN;
            drain_d = DW'(DRAIN);
            wait_d  = 1'b0;
          end
        end
      end

      ST_MEM_WAIT: begin
        pipe_freeze_c = 1'b1;
        pc_en_c       = 1'b0;
        if_id_en_c    = 1'b0;
        if (mem_done) begin
          state_d        = ST_RUN;
          if_id_flush_c  = flush_pend_q;
          id_ex_bubble_c = flush_pend_q;
          flush_pend_d   = 1'b0;
        end
      end

      ST_HALT_DRAIN: begin
        pc_en_c    = 1'b0;
        if_id_en_c = 1'b0;
        // Drain count holds while a cache wait is outstanding inside the drain.
        if (wait_q) begin
          pipe_freeze_c = 1'b1;
          if (mem_done) begin
            wait_d = 1'b0;
            if (drain_q == '0) state_d = ST_HALTED;
          end
        end else begin
          id_ex_bubble_c = 1'b1;
          drain_d        = drain_dec;
          if (miss) wait_d = 1'b1;
          else if (drain_dec == '0) state_d = ST_HALTED;
        end
      end

      ST_HALTED: begin
        pc_en_c       = 1'b0;
        if_id_en_c    = 1'b0;
        pipe_freeze_c = 1'b1;
      end

      default: state_d = ST_RUN;
    endcase

    stall_d = stall_q;
    if (!pc_en_c && (state_q != ST_HALTED) && (stall_q != '1)) stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_RUN;
      flush_pend_q <= 1'b0;
      wait_q       <= 1'b0;
      drain_q      <= '0;
      stall_q      <= '0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
      wait_q       <= wait_d;
      drain_q      <= drain_d;
      stall_q      <= stall_d;
    end
  end

  assign pc_en        = rst ? pc_en_c        : 1'b1;
  assign if_id_en     = rst ? if_id_en_c     : 1'b1;
  assign if_id_flush  = rst ? if_id_flush_c  : 1'b0;
  assign id_ex_bubble = rst ? id_ex_bubble_c : 1'b0;
  assign pipe_freeze  = rst ? pipe_freeze_c  : 1'b0;
  assign halted       = (state_q == ST_HALTED);
  assign stall_cnt    = stall_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  read_reg1, read_reg2, w1_reg_ID_EX;
  logic        rd1_used, rd2_used, reg_en_ID_EX, mem_en_ID_EX, mem_wr_ID_EX;
  logic        halt_ID_EX, branch_taken, mem_req, mem_done;
  logic        pc_en, if_id_en, if_id_flush, id_ex_bubble, pipe_freeze, halted;
  logic [15:0] stall_cnt;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] exp_stall;

  always #5 clk = ~clk;

  hazard_ctrl #(.RW(3), .CNT_W(16), .DRAIN(2)) dut (
    .clk(clk), .rst(rst),
    .read_reg1(read_reg1), .read_reg2(read_reg2),
    .rd1_used(rd1_used), .rd2_used(rd2_used),
    .w1_reg_ID_EX(w1_reg_ID_EX), .reg_en_ID_EX(reg_en_ID_EX),
    .mem_en_ID_EX(mem_en_ID_EX), .mem_wr_ID_EX(mem_wr_ID_EX),
    .halt_ID_EX(halt_ID_EX), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_done(mem_done),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .pipe_freeze(pipe_freeze),
    .halted(halted), .stall_cnt(stall_cnt)
  );

  task automatic idle();
    read_reg1 = '0; read_reg2 = '0; w1_reg_ID_EX = '0;
    rd1_used = 0; rd2_used = 0; reg_en_ID_EX = 0; mem_en_ID_EX = 0; mem_wr_ID_EX = 0;
    halt_ID_EX = 0; branch_taken = 0; mem_req = 0; mem_done = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_r3();
    w1_reg_ID_EX = 3'd3; reg_en_ID_EX = 1; mem_en_ID_EX = 1; mem_wr_ID_EX = 0;
  endtask

  task automatic do_reset();
    rst = 0; idle(); tick(); rst = 1; exp_stall = 0;
  endtask

  task automatic test_reset();
    rst = 0; idle(); load_r3(); read_reg1 = 3'd3; rd1_used = 1; branch_taken = 1; mem_req = 1;
    #3;
    total++; if (pc_en !== 1'b1 || if_id_en !== 1'b1) begin bad++; $display("FAIL reset_en got=%b%b want=11", pc_en, if_id_en); end
    total++; if ({if_id_flush, id_ex_bubble, pipe_freeze} !== 3'b000) begin bad++; $display("FAIL reset_ctl got=%b want=000", {if_id_flush, id_ex_bubble, pipe_freeze}); end
    total++; if (stall_cnt !== 16'd0 || halted !== 1'b0) begin bad++; $display("FAIL reset_state got cnt=%0d halted=%b want 0/0", stall_cnt, halted); end
    tick(); rst = 1; idle(); exp_stall = 0;
  endtask

  task automatic test_load_use();
    load_r3(); read_reg1 = 3'd3; rd1_used = 1; #1;
    total++; if (pc_en !== 1'b0 || if_id_en !== 1'b0 || id_ex_bubble !== 1'b1 || if_id_flush !== 1'b0) begin bad++; $display("FAIL lu_stall got pc=%b ifid=%b bub=%b fl=%b want 0 0 1 0", pc_en, if_id_en, id_ex_bubble, if_id_flush); end
    tick(); idle(); exp_stall++; #1;
    total++; if (pc_en !== 1'b1 || id_ex_bubble !== 1'b0) begin bad++; $display("FAIL lu_release got pc=%b bub=%b want 1 0", pc_en, id_ex_bubble); end
    total++; if (stall_cnt !== exp_stall) begin bad++; $display("FAIL lu_cnt got=%0d want=%0d", stall_cnt, exp_stall); end
  endtask

  task automatic test_no_hazard();
    load_r3(); mem_wr_ID_EX = 1; read_reg1 = 3'd3; rd1_used = 1; #1;
    total++; if (pc_en !== 1'b1 || id_ex_bubble !== 1'b0) begin bad++; $display("FAIL store_nostall got pc=%b bub=%b want 1 0", pc_en, id_ex_bubble); end
    tick(); idle();
    load_r3(); read_reg1 = 3'd5; rd1_used = 1; read_reg2 = 3'd3; rd2_used = 0; #1;
    total++; if (pc_en !== 1'b1 || id_ex_bubble !== 1'b0) begin bad++; $display("FAIL unused_src got pc=%b bub=%b want 1 0", pc_en, id_ex_bubble); end
    rd2_used = 1; #1;
    total++; if (pc_en !== 1'b0 || id_ex_bubble !== 1'b1) begin bad++; $display("FAIL rt_hazard got pc=%b bub=%b want 0 1", pc_en, id_ex_bubble); end
    tick(); idle(); exp_stall++; #1;
    total++; if (stall_cnt !== exp_stall) begin bad++; $display("FAIL nohaz_cnt got=%0d want=%0d", stall_cnt, exp_stall); end
  endtask

  task automatic test_branch();
    load_r3(); read_reg1 = 3'd3; rd1_used = 1; branch_taken = 1; #1;
    total++; if (if_id_flush !== 1'b1 || id_ex_bubble !== 1'b1) begin bad++; $display("FAIL br_flush got fl=%b bub=%b want 1 1", if_id_flush, id_ex_bubble); end
    total++; if (pc_en !== 1'b1 || if_id_en !== 1'b1) begin bad++; $display("FAIL br_pc_en got pc=%b ifid=%b want 1 1", pc_en, if_id_en); end
    tick(); idle(); #1;
    total++; if (stall_cnt !== exp_stall || if_id_flush !== 1'b0) begin bad++; $display("FAIL br_after got cnt=%0d fl=%b want %0d 0", stall_cnt, if_id_flush, exp_stall); end
  endtask

  task automatic test_cache_miss(input logic with_branch);
    mem_req = 1; branch_taken = with_branch; #1;
    total++; if (pc_en !== 1'b1 || pipe_freeze !== 1'b0 || if_id_flush !== 1'b0) begin bad++; $display("FAIL miss_entry br=%b got pc=%b frz=%b fl=%b want 1 0 0", with_branch, pc_en, pipe_freeze, if_id_flush); end
    tick(); idle();
    for (int i = 1; i <= 4; i++) begin
      mem_done = (i == 4); #1;
      total++; if (pipe_freeze !== 1'b1 || pc_en !== 1'b0) begin bad++; $display("FAIL miss_wait%0d br=%b got frz=%b pc=%b want 1 0", i, with_branch, pipe_freeze, pc_en); end
      if (i == 4) begin
        total++; if (if_id_flush !== with_branch || id_ex_bubble !== with_branch) begin bad++; $display("FAIL miss_exit_flush br=%b got fl=%b bub=%b want %b %b", with_branch, if_id_flush, id_ex_bubble, with_branch, with_branch); end
      end
      tick(); idle(); exp_stall++;
    end
    #1;
    total++; if (pipe_freeze !== 1'b0 || if_id_flush !== 1'b0 || stall_cnt !== exp_stall) begin bad++; $display("FAIL miss_done br=%b got frz=%b fl=%b cnt=%0d want 0 0 %0d", with_branch, pipe_freeze, if_id_flush, stall_cnt, exp_stall); end
  endtask

  task automatic test_zero_wait();
    mem_req = 1; mem_done = 1; #1;
    total++; if (pipe_freeze !== 1'b0 || pc_en !== 1'b1) begin bad++; $display("FAIL zw_same got frz=%b pc=%b want 0 1", pipe_freeze, pc_en); end
    tick(); idle(); mem_done = 1; #1;
    total++; if (pipe_freeze !== 1'b0 || pc_en !== 1'b1 || stall_cnt !== exp_stall) begin bad++; $display("FAIL zw_run_done got frz=%b pc=%b cnt=%0d want 0 1 %0d", pipe_freeze, pc_en, stall_cnt, exp_stall); end
    tick(); idle(); #1;
    total++; if (pipe_freeze !== 1'b0) begin bad++; $display("FAIL zw_after got frz=%b want 0", pipe_freeze); end
  endtask

  task automatic test_halt();
    do_reset();
    halt_ID_EX = 1; #1;
    total++; if (pc_en !== 1'b1 || halted !== 1'b0) begin bad++; $display("FAIL halt_issue got pc=%b h=%b want 1 0", pc_en, halted); end
    tick(); idle(); #1;
    total++; if (pc_en !== 1'b0 || id_ex_bubble !== 1'b1 || halted !== 1'b0) begin bad++; $display("FAIL halt_drain got pc=%b bub=%b h=%b want 0 1 0", pc_en, id_ex_bubble, halted); end
    tick(); exp_stall = 1; #1;
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL halt_early got h=%b want 0", halted); end
    tick(); exp_stall = 2; #1;
    total++; if (halted !== 1'b1 || pc_en !== 1'b0) begin bad++; $display("FAIL halt_done got h=%b pc=%b want 1 0", halted, pc_en); end
    tick(); tick(); #1;
    total++; if (halted !== 1'b1 || stall_cnt !== exp_stall) begin bad++; $display("FAIL halt_sticky got h=%b cnt=%0d want 1 %0d", halted, stall_cnt, exp_stall); end
  endtask

  task automatic test_halt_miss();
    do_reset();
    halt_ID_EX = 1; tick(); idle();
    mem_req = 1; tick(); idle();
    for (int c = 2; c <= 5; c++) begin
      mem_done = (c == 4); #1;
      if (c == 2) begin
        total++; if (pipe_freeze !== 1'b1) begin bad++; $display("FAIL hm_freeze got=%b want 1", pipe_freeze); end
      end
      total++; if (halted !== 1'b0) begin bad++; $display("FAIL hm_early%0d got h=%b want 0", c, halted); end
      tick(); idle();
    end
    #1;
    total++; if (halted !== 1'b1 || stall_cnt !== 16'd5) begin bad++; $display("FAIL hm_done got h=%b cnt=%0d want 1 5", halted, stall_cnt); end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    mem_req = 1; branch_taken = 1; tick(); idle(); tick(); tick();
    #2 rst = 0; #1;
    total++; if (pipe_freeze !== 1'b0 || pc_en !== 1'b1 || stall_cnt !== 16'd0 || halted !== 1'b0) begin bad++; $display("FAIL async_rst got frz=%b pc=%b cnt=%0d h=%b want 0 1 0 0", pipe_freeze, pc_en, stall_cnt, halted); end
    tick(); rst = 1; mem_done = 1; #1;
    total++; if (if_id_flush !== 1'b0 || id_ex_bubble !== 1'b0 || pipe_freeze !== 1'b0) begin bad++; $display("FAIL rst_pend_lost got fl=%b bub=%b frz=%b want 0 0 0", if_id_flush, id_ex_bubble, pipe_freeze); end
    tick(); idle(); exp_stall = 0;
  endtask

  task automatic test_saturation();
    do_reset();
    mem_req = 1; tick(); idle();
    repeat (65534) @(posedge clk);
    #1;
    total++; if (stall_cnt !== 16'hFFFE) begin bad++; $display("FAIL sat_near got=%h want=fffe", stall_cnt); end
    repeat (7) @(posedge clk);
    #1;
    total++; if (stall_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%h want=ffff", stall_cnt); end
    mem_done = 1; tick(); idle(); #1;
    total++; if (stall_cnt !== 16'hFFFF || pipe_freeze !== 1'b0) begin bad++; $display("FAIL sat_exit got cnt=%h frz=%b want ffff 0", stall_cnt, pipe_freeze); end
  endtask

  initial begin
    rst = 0; idle(); exp_stall = 0;
    test_reset();
    test_load_use();
    test_no_hazard();
    test_branch();
    test_cache_miss(1'b0);
    test_cache_miss(1'b1);
    test_zero_wait();
    test_halt();
    test_halt_miss();
    test_reset_mid_wait();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
